// File: rtl/cache_pkg.sv
// Shared types, default geometry and address-field helpers for the
// set-associative write-through cache controller.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR      = 2'd2
   } state_t;

   localparam int DEF_SETS        = 64;
   localparam int DEF_WAYS        = 2;
   localparam int DEF_LINE_WORDS  = 2;
   localparam int DEF_USED_ADDR_W = 18;

   // Field widths of the default geometry; modules derive their own from parameters.
   localparam int WSEL_W = $clog2(DEF_LINE_WORDS);
   localparam int IDX_W  = $clog2(DEF_SETS);
   localparam int TAG_W  = DEF_USED_ADDR_W - 2 - WSEL_W - IDX_W;
   localparam int AGE_W  = (DEF_WAYS > 1) ? $clog2(DEF_WAYS) : 1;

   function automatic logic [31:0] addr_field(input logic [31:0] a, input int lsb,
                                              input int width);
      logic [31:0] mask;
      mask = (32'd1 << width) - 32'd1;
      return (a >> lsb) & mask;
   endfunction

   function automatic logic [31:0] word_field(input logic [31:0] a, input int sel_w);
      return addr_field(a, 2, sel_w);
   endfunction

   function automatic logic [31:0] index_field(input logic [31:0] a, input int sel_w,
                                               input int idx_w);
      return addr_field(a, 2 + sel_w, idx_w);
   endfunction

   function automatic logic [31:0] tag_field(input logic [31:0] a, input int sel_w,
                                             input int idx_w, input int used_w);
      return addr_field(a, 2 + sel_w + idx_w, used_w - 2 - sel_w - idx_w);
   endfunction

endpackage

// File: rtl/assoc_cache_ctrl_if.sv
// MEM-stage and SRAM-side signal bundle of the cache controller.
interface assoc_cache_ctrl_if #(
   parameter int LINE_WORDS = 2
);
   // Handshake: a request (mem_r_en/mem_w_en) is held stable until the cycle
   // ready=1, which is the completion cycle; an SRAM request (sram_read/
   // sram_write) is held until sram_ready=1, which completes it in that cycle.
   logic [31:0]              address;
   logic [31:0]              wdata;
   logic                     mem_r_en;
   logic                     mem_w_en;
   logic                     flush;
   logic [31:0]              rdata;
   logic                     ready;
   logic [31:0]              sram_address;
   logic [31:0]              sram_wdata;
   logic                     sram_read;
   logic                     sram_write;
   logic [32*LINE_WORDS-1:0] sram_rdata;
   logic                     sram_ready;

   modport master (
      output address, wdata, mem_r_en, mem_w_en, flush, sram_rdata, sram_ready,
      input  rdata, ready, sram_address, sram_wdata, sram_read, sram_write
   );

   modport slave (
      input  address, wdata, mem_r_en, mem_w_en, flush, sram_rdata, sram_ready,
      output rdata, ready, sram_address, sram_wdata, sram_read, sram_write
   );
endinterface

// File: rtl/cache_lru.sv
// Per-set true-LRU ages: touch update and victim choice (first invalid way,
// else the oldest way).
module cache_lru
   import cache_pkg::*;
#(
   parameter  int SETS     = DEF_SETS,
   parameter  int WAYS     = DEF_WAYS,
   localparam int IDX_BITS = $clog2(SETS),
   localparam int AGE_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] set_idx,
   input  logic [WAYS-1:0]     valid_vec,
   input  logic                touch_en,
   input  logic [AGE_BITS-1:0] touch_way,
   output logic [AGE_BITS-1:0] victim
);

   logic [SETS-1:0][WAYS-1:0][AGE_BITS-1:0] age_q;
   logic [WAYS-1:0][AGE_BITS-1:0]           age_init;
   logic                                    found;

   always_comb begin
      age_init = '0;
      for (int w = 0; w < WAYS; w++) age_init[w] = AGE_BITS'(w);
   end

   // Ages stay a permutation of 0..WAYS-1, so exactly one way is oldest.
   always_ff @(posedge clk) begin
      if (rst) begin
         age_q <= {SETS{age_init}};
      end else if (touch_en) begin
         for (int w = 0; w < WAYS; w++) begin
            if (AGE_BITS'(w) == touch_way)
               age_q[set_idx][w] <= '0;
            else if (age_q[set_idx][w] < age_q[set_idx][touch_way])
               age_q[set_idx][w] <= age_q[set_idx][w] + AGE_BITS'(1);
         end
      end
   end

   always_comb begin
      victim = '0;
      found  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found && !valid_vec[w]) begin
            victim = AGE_BITS'(w);
            found  = 1'b1;
         end
      end
      if (!found) begin
         for (int w = 0; w < WAYS; w++)
            if (age_q[set_idx][w] == AGE_BITS'(WAYS - 1)) victim = AGE_BITS'(w);
      end
   end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative, write-through, no-write-allocate cache between the
// MEM stage and the SRAM controller.
module assoc_cache_ctrl
   import cache_pkg::*;
#(
   parameter int SETS        = DEF_SETS,
   parameter int WAYS        = DEF_WAYS,
   parameter int LINE_WORDS  = DEF_LINE_WORDS,
   parameter int USED_ADDR_W = DEF_USED_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   assoc_cache_ctrl_if.slave bus,
   output state_t            dbg_state
);

   localparam int SEL_BITS = $clog2(LINE_WORDS);
   localparam int IDX_BITS = $clog2(SETS);
   localparam int TAG_BITS = USED_ADDR_W - 2 - SEL_BITS - IDX_BITS;
   localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int LINE_W   = 32 * LINE_WORDS;
   localparam logic [31:0] LINE_MASK = ~(32'(4 * LINE_WORDS) - 32'd1);

   state_t state_q, state_d;

   logic [SETS-1:0][WAYS-1:0] valid_q;
   logic [TAG_BITS-1:0]       tag_q  [SETS][WAYS];
   logic [LINE_W-1:0]         data_q [SETS][WAYS];

   logic [SEL_BITS-1:0] wsel;
   logic [IDX_BITS-1:0] idx;
   logic [TAG_BITS-1:0] tag;
   logic                hit;
   logic [WAY_BITS-1:0] hit_way;
   logic [LINE_W-1:0]   hit_line;
   logic [WAY_BITS-1:0] victim;
   logic                touch_en;
   logic [WAY_BITS-1:0] touch_way;
   logic                fill_en;
   logic                wr_hit_en;
   logic                flush_en;

   assign wsel      = SEL_BITS'(word_field(bus.address, SEL_BITS));
   assign idx       = IDX_BITS'(index_field(bus.address, SEL_BITS, IDX_BITS));
   assign tag       = TAG_BITS'(tag_field(bus.address, SEL_BITS, IDX_BITS, USED_ADDR_W));
   assign dbg_state = state_q;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
            hit     = 1'b1;
            hit_way = WAY_BITS'(w);
         end
      end
   end

   assign hit_line = data_q[idx][hit_way];

   cache_lru #(
      .SETS (SETS),
      .WAYS (WAYS)
   ) u_lru (
      .clk       (clk),
      .rst       (rst),
      .set_idx   (idx),
      .valid_vec (valid_q[idx]),
      .touch_en  (touch_en),
      .touch_way (touch_way),
      .victim    (victim)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Everything is gated by rst so an in-flight transaction is dropped cleanly.
   always_comb begin
      state_d          = state_q;
      bus.ready        = 1'b0;
      bus.rdata        = '0;
      bus.sram_read    = 1'b0;
      bus.sram_write   = 1'b0;
      bus.sram_address = '0;
      bus.sram_wdata   = '0;
      touch_en         = 1'b0;
      touch_way        = '0;
      fill_en          = 1'b0;
      wr_hit_en        = 1'b0;
      flush_en         = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (bus.flush) begin
                  flush_en = 1'b1;
               end else if (bus.mem_w_en) begin
                  state_d   = WR;
                  wr_hit_en = hit;
                  touch_en  = hit;
                  touch_way = hit_way;
               end else if (bus.mem_r_en && hit) begin
                  bus.ready = 1'b1;
                  bus.rdata = hit_line[32*wsel +: 32];
                  touch_en  = 1'b1;
                  touch_way = hit_way;
               end else if (bus.mem_r_en) begin
                  state_d = RD_MISS;
               end else begin
                  bus.ready = 1'b1;
               end
            end
            RD_MISS: begin
               bus.sram_read    = 1'b1;
               bus.sram_address = bus.address & LINE_MASK;
               if (bus.sram_ready) begin
                  fill_en   = 1'b1;
                  touch_en  = 1'b1;
                  touch_way = victim;
                  bus.ready = 1'b1;
                  bus.rdata = bus.sram_rdata[32*wsel +: 32];
                  state_d   = IDLE;
               end
            end
            WR: begin
               bus.sram_write   = 1'b1;
               bus.sram_address = bus.address;
               bus.sram_wdata   = bus.wdata;
               if (bus.sram_ready) begin
                  bus.ready = 1'b1;
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_en)  valid_q              <= '0;
      else if (fill_en)     valid_q[idx][victim] <= 1'b1;
   end

   // A write hit updates the line in place; a write miss allocates nothing.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         data_q[idx][victim] <= bus.sram_rdata;
         tag_q[idx][victim]  <= tag;
      end else if (wr_hit_en) begin
         data_q[idx][hit_way][32*wsel +: 32] <= bus.wdata;
      end
   end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Scenario bench for assoc_cache_ctrl with a 3-cycle SRAM model and a
// memory-content scoreboard.
module tb_assoc_cache_ctrl;
   import cache_pkg::*;

   localparam int MISS = 0;
   localparam int HIT  = 1;
   localparam int ANY  = 2;

   logic   clk = 1'b0;
   logic   rst;
   state_t dbg_state;

   always #5 clk = ~clk;

   assoc_cache_ctrl_if #(.LINE_WORDS(2)) bus ();

   assoc_cache_ctrl #(
      .SETS        (64),
      .WAYS        (2),
      .LINE_WORDS  (2),
      .USED_ADDR_W (18)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [63:0] line_mem [logic [31:0]];
   int          sram_cnt;
   bit          ready_pulse = 1'b0;

   // SRAM decodes only the used address bits.
   function automatic logic [31:0] line_key(input logic [31:0] a);
      return a & 32'h0003_FFF8;
   endfunction

   function automatic logic [63:0] sram_line(input logic [31:0] a);
      logic [31:0] k;
      k = line_key(a);
      if (line_mem.exists(k)) return line_mem[k];
      return {k ^ 32'h5A5A_0001, k ^ 32'hC3C3_0000};
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [63:0] l;
      l = sram_line(a);
      return a[2] ? l[63:32] : l[31:0];
   endfunction

   // SRAM model: answers in the third cycle of a held request.
   initial begin
      bus.sram_ready = 1'b0;
      bus.sram_rdata = '0;
      sram_cnt       = 0;
      forever begin
         @(posedge clk);
         #2;
         if (bus.sram_read || bus.sram_write) begin
            sram_cnt++;
            bus.sram_ready = (sram_cnt == 3) || ready_pulse;
         end else begin
            sram_cnt       = 0;
            bus.sram_ready = ready_pulse;
         end
         bus.sram_rdata = sram_line(bus.sram_address);
      end
   end

   always @(negedge clk) begin
      if (bus.sram_write && bus.sram_ready) begin
         logic [63:0] l;
         l = sram_line(bus.sram_address);
         if (bus.sram_address[2]) l[63:32] = bus.sram_wdata;
         else                     l[31:0]  = bus.sram_wdata;
         line_mem[line_key(bus.sram_address)] = l;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Entered and left at posedge+1 with all request enables low.
   task automatic do_load(input logic [31:0] a, input int mode, input string name);
      int cyc;
      bit done;
      logic [31:0] exp;
      exp = mem_word(a);
      bus.address  = a;
      bus.mem_r_en = 1'b1;
      exp_q.push_back(exp);
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         if (cyc == 0 && mode == HIT) begin
            checks++;
            if (bus.sram_read !== 1'b0) begin
               errors++;
               $display("FAIL %s hit_sram_read: got %b want 0", name, bus.sram_read);
            end
         end
         if (cyc == 1 && mode == MISS) begin
            checks++;
            if (bus.sram_read !== 1'b1 || bus.sram_address !== {a[31:3], 3'b000}) begin
               errors++;
               $display("FAIL %s miss_request: sram_read=%b addr=%h want 1 addr=%h",
                        name, bus.sram_read, bus.sram_address, {a[31:3], 3'b000});
            end
         end
         if (bus.ready === 1'b1) begin
            done = 1'b1;
            checks++;
            if (bus.rdata !== exp_q[0]) begin
               errors++;
               $display("FAIL %s rdata: got %h want %h", name, bus.rdata, exp_q[0]);
            end
            void'(exp_q.pop_front());
            if (mode != ANY) begin
               checks++;
               if (cyc != ((mode == HIT) ? 0 : 3)) begin
                  errors++;
                  $display("FAIL %s latency: got %0d want %0d", name, cyc,
                           (mode == HIT) ? 0 : 3);
               end
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.mem_r_en = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no ready within %0d cycles", name, cyc);
         void'(exp_q.pop_front());
      end
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input string name);
      int cyc;
      bit done;
      bus.address  = a;
      bus.wdata    = d;
      bus.mem_w_en = 1'b1;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         if (cyc == 1) begin
            checks++;
            if (bus.sram_write !== 1'b1 || bus.sram_address !== a || bus.sram_wdata !== d) begin
               errors++;
               $display("FAIL %s wr_request: wr=%b addr=%h data=%h want 1 %h %h",
                        name, bus.sram_write, bus.sram_address, bus.sram_wdata, a, d);
            end
         end
         if (bus.ready === 1'b1) begin
            done = 1'b1;
            checks++;
            if (cyc != 3 || bus.rdata !== 32'h0) begin
               errors++;
               $display("FAIL %s wr_done: cycle=%0d rdata=%h want 3 0", name, cyc, bus.rdata);
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.mem_w_en = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no ready within %0d cycles", name, cyc);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.address  = 32'h100;
      bus.mem_r_en = 1'b1;
      repeat (2) @(posedge clk);
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (bus.ready !== 1'b0 || bus.rdata !== 32'h0 || bus.sram_read !== 1'b0 ||
             bus.sram_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rdata=%h rd=%b wr=%b want all 0",
                     bus.ready, bus.rdata, bus.sram_read, bus.sram_write);
         end
      end
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.mem_r_en = 1'b0;
      @(negedge clk);
      checks++;
      if (dbg_state !== IDLE || bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle: state=%0d ready=%b want 0 1", dbg_state, bus.ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_read_miss_fill();
      line_mem[32'h100] = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
      do_load(32'h104, MISS, "miss_fill_104");
      do_load(32'h100, HIT, "hit_after_fill_100");
   endtask

   task automatic test_lru();
      do_load(32'h100, HIT,  "lru_100_a");
      do_load(32'h300, MISS, "lru_300_a");
      do_load(32'h100, HIT,  "lru_100_b");
      do_load(32'h500, MISS, "lru_500");
      do_load(32'h100, HIT,  "lru_100_c");
      do_load(32'h300, MISS, "lru_300_evicted");
   endtask

   task automatic test_write_through();
      do_store(32'h104, 32'h1234_5678, "wr_hit_104");
      do_load(32'h104, HIT, "rd_after_wr_104");
      do_store(32'h704, 32'hCAFE_F00D, "wr_miss_704");
      do_load(32'h704, MISS, "rd_after_wr_miss_704");
   endtask

   task automatic test_flush();
      do_load(32'h100, HIT, "flush_pre_100");
      bus.flush = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'b0 || bus.sram_read !== 1'b0) begin
         errors++;
         $display("FAIL flush_cycle: ready=%b sram_read=%b want 0 0", bus.ready, bus.sram_read);
      end
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      do_load(32'h100, MISS, "flush_post_100");
      do_load(32'h8000_0100, HIT, "upper_bits_ignored");
   endtask

   task automatic test_reset_abort();
      bus.address  = 32'h908;
      bus.mem_r_en = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (bus.sram_read !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: sram_read=%b want 1", bus.sram_read);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.sram_read !== 1'b0 || bus.ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_rst: sram_read=%b ready=%b want 0 0", bus.sram_read, bus.ready);
      end
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.mem_r_en = 1'b0;
      @(negedge clk);
      checks++;
      if (dbg_state !== IDLE || bus.sram_read !== 1'b0) begin
         errors++;
         $display("FAIL abort_after: state=%0d sram_read=%b want 0 0", dbg_state, bus.sram_read);
      end
      @(posedge clk);
      #1;
      ready_pulse = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.sram_ready !== 1'b1 || bus.ready !== 1'b1 || bus.sram_read !== 1'b0) begin
         errors++;
         $display("FAIL late_ready: sram_ready=%b ready=%b sram_read=%b want 1 1 0",
                  bus.sram_ready, bus.ready, bus.sram_read);
      end
      @(posedge clk);
      #1;
      ready_pulse = 1'b0;
      @(negedge clk);
      checks++;
      if (dbg_state !== IDLE) begin
         errors++;
         $display("FAIL late_ready_state: got %0d want 0", dbg_state);
      end
      @(posedge clk);
      #1;
      do_load(32'h100, MISS, "after_abort_100");
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      for (int i = 0; i < 24; i++) begin
         a = {20'h0, 3'($urandom_range(0, 3)), 6'(32 + $urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 2'b00};
         if ($urandom_range(0, 2) == 0) do_store(a, $urandom, "b2b_store");
         else                           do_load(a, ANY, "b2b_load");
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
      end
   endtask

   initial begin
      bus.address  = '0;
      bus.wdata    = '0;
      bus.mem_r_en = 1'b0;
      bus.mem_w_en = 1'b0;
      bus.flush    = 1'b0;
      test_reset();
      test_read_miss_fill();
      test_lru();
      test_write_through();
      test_flush();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
